// File: rtl/hmac_arbiter.sv
// hmac_arbiter: round-robin arbiter sharing one hmac_sha256 core between two requesters.
// Optional HMAC_ARB_TIMEOUT_EN adds a WAIT_CLR/BUSY watchdog that aborts after TIMEOUT_CYCLES.
module hmac_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0,
  input  logic         req1,
  input  logic [511:0] key0,
  input  logic [511:0] key1,
  input  logic [511:0] data0,
  input  logic [511:0] data1,
  output logic [1:0]   grant,
  output logic         done0,
  output logic         done1,
  output logic [255:0] hmac_out,
  output logic         busy,
  output logic         timeout_err,
  output logic         core_go,
  output logic [511:0] core_key,
  output logic [511:0] core_data,
  input  logic         core_data_available,
  input  logic [255:0] core_hmac
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CLR, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, done_q, done_d;
  logic last_q, last_d, go_q, go_d, terr_q, terr_d, tmo;
  logic [255:0] hmac_q, hmac_d;
`ifdef HMAC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic waiting;
  assign waiting = (state_q == WAIT_CLR) || (state_q == BUSY);
  assign cnt_d = waiting ? cnt_q + 1'b1 : '0;
  assign tmo = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_tc;
  assign unused_tc = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    go_d = 1'b0;
    done_d = 2'b00;
    terr_d = 1'b0;
    hmac_d = '0;
    case (state_q)
      IDLE: if (req0 || req1) begin
        // last_q=1 means requester 1 was served last, so requester 0 wins a tie
        grant_d = (req0 && (!req1 || last_q)) ? 2'b01 : 2'b10;
        go_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT_CLR;
      WAIT_CLR: if (!core_data_available) state_d = BUSY;
      BUSY: if (core_data_available) begin
        hmac_d = core_hmac;
        done_d = grant_q;
        state_d = DONE;
      end
      DONE: begin
        grant_d = 2'b00;
        last_d = grant_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo && !(state_q == BUSY && core_data_available)) begin
      done_d = grant_q;
      terr_d = 1'b1;
      hmac_d = '0;
      state_d = DONE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q <= 1'b1;
      go_q <= 1'b0;
      done_q <= 2'b00;
      terr_q <= 1'b0;
      hmac_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      go_q <= go_d;
      done_q <= done_d;
      terr_q <= terr_d;
      hmac_q <= hmac_d;
    end
  end
  assign grant = grant_q;
  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign hmac_out = hmac_q;
  assign busy = state_q != IDLE;
  assign timeout_err = terr_q;
  assign core_go = go_q;
  assign core_key = grant_q[0] ? key0 : grant_q[1] ? key1 : '0;
  assign core_data = grant_q[0] ? data0 : grant_q[1] ? data1 : '0;
endmodule

// File: tb/tb_hmac_arbiter.sv
// tb_hmac_arbiter: table-driven cycle vectors plus a hand-written watchdog sequence.
module tb_hmac_arbiter;
  logic CLK = 1'b0, RST = 1'b1, req0 = 1'b0, req1 = 1'b0, core_data_available = 1'b1;
  logic [511:0] key0, key1, data0, data1, core_key, core_data;
  logic [255:0] hmac_out, core_hmac, h0, h1;
  logic [1:0] grant;
  logic done0, done1, busy, timeout_err, core_go;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {
    logic rst, r0, r1, av;
    logic [1:0] g;
    logic go, d0, d1, bz;
    logic [1:0] h;
  } vec_t;
  vec_t tbl[$];
  always #5 CLK = ~CLK;
  assign core_hmac = core_key[255:0] ^ core_data[511:256];
  hmac_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
    .key0(key0), .key1(key1), .data0(data0), .data1(data1),
    .grant(grant), .done0(done0), .done1(done1), .hmac_out(hmac_out),
    .busy(busy), .timeout_err(timeout_err), .core_go(core_go),
    .core_key(core_key), .core_data(core_data),
    .core_data_available(core_data_available), .core_hmac(core_hmac)
  );
  function automatic void v(input logic rst, r0, r1, av, input logic [1:0] g,
                            input logic go, d0, d1, bz, input logic [1:0] h);
    tbl.push_back('{rst, r0, r1, av, g, go, d0, d1, bz, h});
  endfunction
  task automatic step(input logic rst, r0, r1, av);
    @(negedge CLK);
    RST = rst;
    req0 = r0;
    req1 = r1;
    core_data_available = av;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [1:0] g, input logic go, d0, d1, bz, te,
                     input logic [1:0] h);
    logic [5:0] ea, aa;
    logic [255:0] eh;
    logic [511:0] ek, ed;
    ea = {g, go, d0, d1, bz} << 1 | {5'b0, te};
    aa = {grant, core_go, done0, done1, busy, timeout_err};
    eh = (h == 2'd1) ? h0 : (h == 2'd2) ? h1 : '0;
    ek = g[0] ? key0 : g[1] ? key1 : '0;
    ed = g[0] ? data0 : g[1] ? data1 : '0;
    n_chk += 4;
    if (aa === ea) n_pass++;
    else $display("FAIL %s ctrl {grant,go,done0,done1,busy,terr}: got %b want %b", nm, aa, ea);
    if (hmac_out === eh) n_pass++;
    else $display("FAIL %s hmac_out: got %h want %h", nm, hmac_out, eh);
    if (core_key === ek) n_pass++;
    else $display("FAIL %s core_key: got %h want %h", nm, core_key, ek);
    if (core_data === ed) n_pass++;
    else $display("FAIL %s core_data: got %h want %h", nm, core_data, ed);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) key0[511-8*i -: 8] = 8'(i);
    data0 = {32'h61626380, 416'b0, 64'h18};
    key1 = ~key0;
    data1 = {16{32'hdeadbeef}};
    h0 = key0[255:0] ^ data0[511:256];
    h1 = key1[255:0] ^ data1[511:256];
    // rst r0 r1 av | grant go d0 d1 busy hsel
    v(1,0,0,1, 0,0,0,0,0,0);
    v(0,1,0,1, 1,1,0,0,1,0);
    v(0,1,0,1, 1,0,0,0,1,0);
    v(0,1,0,1, 1,0,0,0,1,0);
    v(0,1,0,0, 1,0,0,0,1,0);
    v(0,1,0,0, 1,0,0,0,1,0);
    v(0,1,0,1, 1,0,1,0,1,1);
    v(0,0,0,1, 0,0,0,0,0,0);
    v(1,1,1,1, 0,0,0,0,0,0);
    v(0,1,1,1, 1,1,0,0,1,0);
    v(0,1,1,0, 1,0,0,0,1,0);
    v(0,1,1,0, 1,0,0,0,1,0);
    v(0,1,1,1, 1,0,1,0,1,1);
    v(0,1,1,1, 0,0,0,0,0,0);
    v(0,1,1,1, 2,1,0,0,1,0);
    v(0,1,1,0, 2,0,0,0,1,0);
    v(0,1,1,0, 2,0,0,0,1,0);
    v(0,1,1,1, 2,0,0,1,1,2);
    v(0,1,1,1, 0,0,0,0,0,0);
    v(0,1,1,1, 1,1,0,0,1,0);
    v(0,1,1,0, 1,0,0,0,1,0);
    v(0,1,1,0, 1,0,0,0,1,0);
    v(0,1,1,1, 1,0,1,0,1,1);
    v(0,1,1,1, 0,0,0,0,0,0);
    v(0,1,1,1, 2,1,0,0,1,0);
    v(0,1,1,0, 2,0,0,0,1,0);
    v(0,1,1,0, 2,0,0,0,1,0);
    v(0,1,1,1, 2,0,0,1,1,2);
    v(0,0,1,1, 0,0,0,0,0,0);
    v(0,0,1,1, 2,1,0,0,1,0);
    v(0,0,1,0, 2,0,0,0,1,0);
    v(0,0,1,0, 2,0,0,0,1,0);
    v(1,0,1,1, 0,0,0,0,0,0);
    v(0,0,1,1, 2,1,0,0,1,0);
    v(0,1,1,0, 2,0,0,0,1,0);
    v(0,1,0,0, 2,0,0,0,1,0);
    v(0,1,0,1, 2,0,0,1,1,2);
    v(0,1,0,1, 0,0,0,0,0,0);
    v(0,1,0,1, 1,1,0,0,1,0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].av);
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].go, tbl[i].d0, tbl[i].d1, tbl[i].bz, 1'b0, tbl[i].h);
    end
    // core never completes: watchdog aborts when compiled in, otherwise the FSM keeps waiting
    step(1,0,0,1);
    chk("wd_rst", 0,0,0,0,0,0,0);
    step(0,1,0,1);
    chk("wd_launch", 1,1,0,0,1,0,0);
    for (int n = 1; n <= 16; n++) begin
      step(0,1,0,0);
      chk($sformatf("wd_wait%0d", n), 1,0,0,0,1,0,0);
    end
    step(0,0,0,0);
`ifdef HMAC_ARB_TIMEOUT_EN
    chk("wd_abort", 1,0,1,0,1,1,0);
    step(0,0,0,0);
    chk("wd_idle", 0,0,0,0,0,0,0);
`else
    chk("wd_hold", 1,0,0,0,1,0,0);
    step(0,0,0,1);
    chk("wd_done", 1,0,1,0,1,0,1);
    step(0,0,0,1);
    chk("wd_idle", 0,0,0,0,0,0,0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
